// File: rtl/fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// presents fetched instructions to regD with a one-entry skid buffer under stall.
module fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_i_regF_stall,
  input  logic            execute_i_need_jump,
  input  logic [XLEN-1:0] execute_i_jump_pc,
  output logic            imem_o_req_valid,
  output logic [XLEN-1:0] imem_o_req_addr,
  input  logic            imem_i_req_ready,
  input  logic            imem_i_resp_valid,
  input  logic [ILEN-1:0] imem_i_resp_inst,
  output logic            fetch_o_valid,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [ILEN-1:0] fetch_o_inst,
  output logic            fetch_o_busy
);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [ILEN-1:0] out_inst_q, out_inst_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [ILEN-1:0] skid_inst_q, skid_inst_d;

  logic consumed_c;
  logic req_valid_c;
  logic handshake_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    consumed_c  = out_valid_q & ~ctrl_i_regF_stall;
    // A request is only issued when its response is guaranteed a slot.
    req_valid_c = (state_q == S_REQ) & ~skid_valid_q & (~out_valid_q | consumed_c);
    handshake_c = req_valid_c & imem_i_req_ready;

    if (execute_i_need_jump) begin
      pc_d         = {execute_i_jump_pc[XLEN-1:2], 2'b00};
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      drop_d       = 1'b0;
      state_d      = S_REQ;
      if (state_q == S_WAIT && !imem_i_resp_valid) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else if (handshake_c) begin
        // Old-path request already accepted; its response must be discarded.
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end
    end else begin
      if (consumed_c) begin
        if (skid_valid_q) begin
          out_pc_d     = skid_pc_q;
          out_inst_d   = skid_inst_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      unique case (state_q)
        S_REQ: begin
          if (handshake_c) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_i_resp_valid) begin
            state_d = S_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = req_pc_q + XLEN'(4);
              if (!out_valid_q || consumed_c) begin
                out_valid_d = 1'b1;
                out_pc_d    = req_pc_q;
                out_inst_d  = imem_i_resp_inst;
              end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_inst_d  = imem_i_resp_inst;
              end
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_o_req_valid = req_valid_c & ~rst;
  assign imem_o_req_addr  = pc_q;
  assign fetch_o_valid    = out_valid_q;
  assign fetch_o_pc       = out_pc_q;
  assign fetch_o_inst     = out_inst_q;
  assign fetch_o_busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: a queue-based reference model tracks the
// instruction stream while a simple memory answers requests after 1-3 cycles.
module tb_fetch;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int          NCYC   = 4000;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            jump;
  logic [XLEN-1:0] jump_pc;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic [ILEN-1:0] resp_inst;
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [ILEN-1:0] f_inst;
  logic            f_busy;

  always #5 clk = ~clk;

  fetch #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ctrl_i_regF_stall   (stall),
    .execute_i_need_jump (jump),
    .execute_i_jump_pc   (jump_pc),
    .imem_o_req_valid    (req_valid),
    .imem_o_req_addr     (req_addr),
    .imem_i_req_ready    (req_ready),
    .imem_i_resp_valid   (resp_valid),
    .imem_i_resp_inst    (resp_inst),
    .fetch_o_valid       (f_valid),
    .fetch_o_pc          (f_pc),
    .fetch_o_inst        (f_inst),
    .fetch_o_busy        (f_busy)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model: pending instructions toward regD (at most two), fetch PC,
  // whether a request is in flight and whether its response is doomed.
  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [63:0] m_req_pc;
  bit          m_wait;
  bit          m_drop;

  bit mem_pend;
  int mem_dly;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'h8000_0102;
      1:       t = 64'hFFFF_FFFF_FFFF_FFFE;
      2:       t = {32'h0, $urandom()};
      default: t = {$urandom(), $urandom()};
    endcase
    return t;
  endfunction

  initial begin
    bit   consumed;
    bit   exp_req;
    bit   m_hs;
    logic hs;
    ent_t e;

    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_pc = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_inst = '0;
    m_pc = RST_PC; m_req_pc = '0; m_wait = 0; m_drop = 0;
    mem_pend = 0; mem_dly = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst       = (c < 3) || ($urandom_range(0, 79) == 0);
      stall     = ($urandom_range(0, 9) < 3);
      jump      = ($urandom_range(0, 11) == 0);
      jump_pc   = pick_target();
      req_ready = ($urandom_range(0, 9) < 7);
      resp_inst = $urandom();
      if (mem_pend && mem_dly == 0) begin
        resp_valid = 1'b1;
        mem_pend   = 0;
      end else begin
        if (mem_pend) mem_dly--;
        // Stray responses with nothing outstanding must be ignored.
        resp_valid = !mem_pend && ($urandom_range(0, 7) == 0);
      end
      #1;

      consumed = (mq.size() > 0) && !stall;
      exp_req  = !rst && !m_wait && (mq.size() == 0 || (mq.size() == 1 && consumed));
      check_eq("req_valid", 64'(req_valid), 64'(exp_req));
      check_eq("req_addr", req_addr, m_pc);
      check_eq("out_valid", 64'(f_valid), 64'(mq.size() > 0));
      check_eq("busy", 64'(f_busy), 64'(m_wait));
      if (mq.size() > 0) begin
        check_eq("out_pc", f_pc, mq[0].pc);
        check_eq("out_inst", 64'(f_inst), 64'(mq[0].inst));
      end
      hs   = req_valid & req_ready;
      m_hs = exp_req && req_ready;

      @(posedge clk);
      if (hs === 1'b1) begin
        mem_pend = 1;
        mem_dly  = $urandom_range(0, 2);
      end

      if (rst) begin
        mq.delete();
        m_pc = RST_PC; m_wait = 0; m_drop = 0;
      end else if (jump) begin
        mq.delete();
        m_pc = jump_pc & ~64'h3;
        if (m_wait) begin
          m_drop = !resp_valid;
          m_wait = !resp_valid;
        end else begin
          m_drop = m_hs;
          m_wait = m_hs;
        end
      end else begin
        if (consumed) void'(mq.pop_front());
        if (m_wait) begin
          if (resp_valid) begin
            if (!m_drop) begin
              e.pc   = m_req_pc;
              e.inst = resp_inst;
              mq.push_back(e);
              m_pc = m_req_pc + 64'd4;
            end
            m_drop = 0;
            m_wait = 0;
          end
        end else if (m_hs) begin
          m_req_pc = m_pc;
          m_wait   = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Fetch stage that consumes the hazard unit's stall and redirect signals and produces the instruction stream for regD.
- Owns the PC and drives a valid/ready instruction-memory request channel with at most one request outstanding.
- Holds its output stable under stall, using a one-entry skid buffer for responses that arrive while stalled.
- On a taken jump from execute, redirects the PC, flushes buffered instructions and drops any in-flight response.

Parameters:
- XLEN, 64, address/PC width.
- ILEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ctrl_i_regF_stall  in  1  hold current output; no consume this cycle.
- execute_i_need_jump  in  1  redirect and flush this cycle.
- execute_i_jump_pc  in  XLEN  redirect target.
- imem_o_req_valid  out  1  request valid.
- imem_o_req_addr  out  XLEN  request address.
- imem_i_req_ready  in  1  memory accepts request.
- imem_i_resp_valid  in  1  response valid, one cycle, no backpressure.
- imem_i_resp_inst  in  ILEN  response instruction.
- fetch_o_valid  out  1  instruction valid toward regD.
- fetch_o_pc  out  XLEN  PC of fetch_o_inst.
- fetch_o_inst  out  ILEN  instruction toward regD.
- fetch_o_busy  out  1  request outstanding (state WAIT).

Behaviour:
- Reset (sync, high): pc=RESET_PC, state=REQ, out_valid=0, skid_valid=0, drop=0. All outputs 0 except imem_o_req_addr=RESET_PC.
- Output consume: the out entry is consumed in any cycle where fetch_o_valid=1 and ctrl_i_regF_stall=0.
- Output hold: while stall=1, fetch_o_valid/pc/inst hold stable.
- Refill: when out is consumed, skid moves into out if skid_valid, else out_valid clears unless a response fills it that same cycle.
- State REQ:
  - imem_o_req_valid=1 iff skid_valid=0 and (out_valid=0 or out consumed this cycle); imem_o_req_addr=pc.
  - On valid&ready: req_pc<=pc, go WAIT.
  - Responses arriving in REQ are ignored (stale after reset).
- State WAIT:
  - imem_o_req_valid=0.
  - On resp_valid with drop=1: discard, drop<=0, go REQ.
  - On resp_valid with drop=0: write {req_pc, inst} into out if out is free or consumed this cycle, else into skid; pc<=req_pc+4 (mod 2^XLEN); go REQ.
- Jump (execute_i_need_jump=1) has priority over stall, response and handshake:
  - pc<=execute_i_jump_pc with bits[1:0] forced 0; out_valid<=0; skid_valid<=0.
  - If in WAIT and no response this cycle: drop<=1, stay WAIT.
  - If in WAIT and a response arrives this cycle: discard it, go REQ, drop<=0.
  - If in REQ and a handshake occurs this cycle: the request is accepted; drop<=1, go WAIT.
  - Otherwise go REQ.
  - fetch_o_valid=0 the cycle after a jump.
- Latency: request accepted in cycle N with response in N+1 gives fetch_o_valid=1 in N+2; the next request is in N+2. Throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Skid overflow is impossible: no request is issued while skid_valid=1.
- Reset mid-WAIT: returns to REQ; a late response is ignored.

Test Plan:
- Reset then release, ready=1, 1-cycle memory returning 0x00000013 -> addresses 0x80000000, 0x80000004, 0x80000008; fetch_o_valid pulses with matching pc; busy alternates.
- Stall held 4 cycles while out is valid and a response arrives -> out stable at pc 0x80000004, skid captures 0x80000008, no new request; after release, 0x80000008 appears next cycle, then a request to 0x8000000C.
- Jump to 0x80000102 asserted in WAIT one cycle before the response -> the response is dropped, the next request is to 0x80000100, and no instruction from the old path reaches fetch_o_valid.
- Jump coincident with the response and with stall=1 -> out and skid cleared, response discarded, request to the jump target the following cycle.
- imem_i_req_ready=0 for 3 cycles -> req_valid and addr held stable, pc unchanged; fetch proceeds on the first ready.
- Reset asserted during WAIT, response arrives the cycle after reset -> response ignored, first request to 0x80000000.
